// File: rtl/rand_arbiter_if.sv
// Request/grant bundle between game-logic requesters, the shared 8-bit LFSR and rand_arbiter.
// The arbiter uses the slave modport; requesters plus the LFSR sit on the master side.
`timescale 1ns/1ps
interface rand_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] ack;
   logic [7:0]       rand_out;
   logic             busy;
   logic [7:0]       lfsr_rand;
   logic             lfsr_en;

   modport slave (
      input  req,
      input  lfsr_rand,
      output ack,
      output rand_out,
      output busy,
      output lfsr_en
   );

   modport master (
      output req,
      output lfsr_rand,
      input  ack,
      input  rand_out,
      input  busy,
      input  lfsr_en
   );
endinterface

// File: rtl/rand_arbiter.sv
// Round-robin arbiter sharing one external LFSR; advances it STEPS times per grant before delivery.
// Optional macro RAND_FREE_RUN_EN lets the LFSR free-run outside the LATCH state.
`timescale 1ns/1ps
module rand_arbiter #(
   parameter int N_REQ = 4,
   parameter int STEPS = 8
) (
   input  logic           clk_i,
   input  logic           reset_n_i,
   rand_arbiter_if.slave  bus
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE, STEP, LATCH, ACK} state_e;

   state_e           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [IW-1:0]    grant_q, grant_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [7:0]       rand_q, rand_d;

   logic [IW-1:0]    sel_idx;
   logic [IW-1:0]    cand;
   logic             sel_valid;
   int               sum;

   // Search starts at ptr and wraps, so the requester just served is considered last.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      sum       = 0;
      for (int i = 0; i < N_REQ; i++) begin
         sum = int'(ptr_q) + i;
         if (sum >= N_REQ) sum = sum - N_REQ;
         cand = IW'(sum);
         if (!sel_valid && bus.req[cand]) begin
            sel_valid = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      ack_d   = '0;
      rand_d  = rand_q;
      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               grant_d = sel_idx;
               cnt_d   = 8'(STEPS - 1);
               state_d = STEP;
            end
         end
         STEP: begin
            if (cnt_q == 8'd0) state_d = LATCH;
            else               cnt_d   = cnt_q - 8'd1;
         end
         LATCH: begin
            rand_d         = bus.lfsr_rand;
            ack_d[grant_q] = 1'b1;
            ptr_d          = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);
            state_d        = ACK;
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
         ack_q   <= '0;
         rand_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         ack_q   <= ack_d;
         rand_q  <= rand_d;
      end
   end

`ifdef RAND_FREE_RUN_EN
   // Free-running LFSR pauses only while the delivered byte is being captured.
   assign bus.lfsr_en = reset_n_i && (state_q != LATCH);
`else
   assign bus.lfsr_en = (state_q == STEP);
`endif

   assign bus.ack      = ack_q;
   assign bus.rand_out = rand_q;
   assign bus.busy     = (state_q != IDLE);

endmodule
